// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction ROM and
// holds one IF/ID entry for decode over a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 1024,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

  state_t      state;
  logic [31:0] pc;
  logic        fault_now;
  logic        load;
  logic        accept;

  assign imem_addr = pc;
  // Unsigned compare also catches PCs that wrapped past the top of the address space.
  assign fault_now = (pc[1:0] != 2'b00) || (pc > LAST_PC);
  assign accept    = out_valid && out_ready;
  assign load      = (state == RUN) && (!out_valid || out_ready);

  // NOTE: all state below updates with non-blocking assignments so every register
  // samples the pre-edge values of pc/out_valid; blocking here would chain updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_pc      <= 32'h0;
      out_instr   <= NOP;
      out_fault   <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
      end

      if (redirect_valid) begin
        // Flush the held entry; the ROM word at the old PC is discarded.
        pc        <= redirect_target;
        out_valid <= 1'b0;
        state     <= RUN;
      end else if (load) begin
        out_pc    <= pc;
        out_valid <= 1'b1;
        if (fault_now) begin
          out_instr <= NOP;
          out_fault <= 1'b1;
          state     <= HALT;
        end else begin
          out_instr <= imem_instr;
          out_fault <= 1'b0;
          pc        <= pc + 32'd4;
        end
      end else if (accept) begin
        // Only reachable in HALT: the faulting entry has been taken by decode.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a scoreboard queue holds expected accepted entries,
// a negedge monitor compares every accepted transfer; direct checks cover stalls/bubbles.
module tb_instr_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .MEM_SIZE(1024),
    .NOP     (NOP_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault),
    .fetch_count    (fetch_count)
  );

  // Combinational ROM model; out-of-range reads return a recognisable poison word.
  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_addr < 32'd1024) imem_instr = rom[imem_addr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.fault = fault;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_pc"}, out_pc, 32'h0);
    check({tag, "_instr"}, out_instr, NOP_W);
    check({tag, "_fault"}, {31'h0, out_fault}, 32'h0);
    check({tag, "_count"}, fetch_count, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  // Monitor: every accepted transfer must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got accept of pc 0x%08h expected no transfer", out_pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_pc", out_pc, e.pc);
          check("sb_instr", out_instr, e.instr);
          check("sb_fault", {31'h0, out_fault}, {31'h0, e.fault});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + 32'(i);
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h00A0_0113;
    rom[2] = 32'h0020_81B3;
    rom[3] = 32'h0000_0013;

    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    step(); step();
    @(negedge clk);
    check_reset_state("reset");

    // Reset and stream: four back-to-back accepts.
    step();
    rst = 1'b0; out_ready = 1'b1;
    expect_entry(32'h0, 32'h0050_0093, 1'b0);
    expect_entry(32'h4, 32'h00A0_0113, 1'b0);
    expect_entry(32'h8, 32'h0020_81B3, 1'b0);
    expect_entry(32'hC, 32'h0000_0013, 1'b0);
    repeat (5) step();
    out_ready = 1'b0;
    @(negedge clk);
    check("stream_count", fetch_count, 32'd4);
    check("stream_next_pc", out_pc, 32'h10);

    // Return to 0 and stall on entry 4.
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    expect_entry(32'h0, 32'h0050_0093, 1'b0);
    @(negedge clk);
    check("redir0_bubble", {31'h0, out_valid}, 32'h0);
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {31'h0, out_valid}, 32'h1);
      check("bp_pc", out_pc, 32'h4);
      check("bp_instr", out_instr, 32'h00A0_0113);
      check("bp_addr", imem_addr, 32'h8);
      check("bp_count", fetch_count, 32'd5);
      step();
    end
    out_ready = 1'b1;
    expect_entry(32'h4, 32'h00A0_0113, 1'b0);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_pc", out_pc, 32'h8);
    check("bp_release_count", fetch_count, 32'd6);

    // Redirect to 0x40 while entry 8 is stalled: entry 8 is dropped.
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_bubble", {31'h0, out_valid}, 32'h0);
    check("redir_count", fetch_count, 32'd6);
    check("redir_addr", imem_addr, 32'h40);
    step();
    out_ready = 1'b1;
    expect_entry(32'h40, 32'hA000_0010, 1'b0);
    redirect_valid = 1'b1; redirect_target = 32'h22;
    @(negedge clk);
    check("redir_target_pc", out_pc, 32'h40);

    // Accept 0x40 and redirect to misaligned 0x22 in the same cycle.
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("accept_with_redir_count", fetch_count, 32'd7);
    check("mis_bubble", {31'h0, out_valid}, 32'h0);
    step();
    @(negedge clk);
    check("mis_valid", {31'h0, out_valid}, 32'h1);
    check("mis_pc", out_pc, 32'h22);
    check("mis_instr", out_instr, NOP_W);
    check("mis_fault", {31'h0, out_fault}, 32'h1);
    step();
    out_ready = 1'b1;
    expect_entry(32'h22, NOP_W, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_idle", {31'h0, out_valid}, 32'h0);
      step();
    end
    check("halt_count", fetch_count, 32'd8);

    // Resume at 0, then jump to the last word and run off the end of the ROM.
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    expect_entry(32'h0, 32'h0050_0093, 1'b0);
    step();
    redirect_valid = 1'b1; redirect_target = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    expect_entry(32'h3FC, 32'hA000_00FF, 1'b0);
    expect_entry(32'h400, NOP_W, 1'b1);
    step(); step();
    @(negedge clk);
    check("oor_pc", out_pc, 32'h400);
    check("oor_fault", {31'h0, out_fault}, 32'h1);
    step();
    @(negedge clk);
    check("oor_halt_valid", {31'h0, out_valid}, 32'h0);
    check("oor_count", fetch_count, 32'd11);
    check("oor_addr", imem_addr, 32'h400);
    step();
    @(negedge clk);
    check("oor_halt_hold", {31'h0, out_valid}, 32'h0);

    // Fresh stream of seven accepts, then reset mid-stream.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    expect_entry(32'h00, 32'h0050_0093, 1'b0);
    expect_entry(32'h04, 32'h00A0_0113, 1'b0);
    expect_entry(32'h08, 32'h0020_81B3, 1'b0);
    expect_entry(32'h0C, 32'h0000_0013, 1'b0);
    expect_entry(32'h10, 32'hA000_0004, 1'b0);
    expect_entry(32'h14, 32'hA000_0005, 1'b0);
    expect_entry(32'h18, 32'hA000_0006, 1'b0);
    repeat (8) step();
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    check("pre_rst_count", fetch_count, 32'd7);
    check("pre_rst_pc", out_pc, 32'h1C);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_reset_state("mid_reset");
    rst = 1'b0;
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
